// File: rtl/msb_gate_pkg.sv
// Shared types and defaults for the MSB power-gating controller.
package msb_gate_pkg;

    // Power state of the adder's upper half.
    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        SLEEPING = 2'd1,
        GATED    = 2'd2,
        WAKING   = 2'd3
    } state_e;

    localparam int DEF_IDLE_THRESH = 16;
    localparam int DEF_SLEEP_LAT   = 6;
    localparam int DEF_WAKE_LAT    = 6;

    // An operand pair is wide when either upper half is non-zero.
    function automatic logic is_wide(input logic [15:0] a_hi, input logic [15:0] b_hi);
        return (a_hi != 16'd0) || (b_hi != 16'd0);
    endfunction

endpackage

// File: rtl/lat_timer.sv
// Loadable down-counter; o_done is high during the last cycle of a loaded interval.
module lat_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load a new interval or count the current one down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // A loaded value of N gives N cycles; the N-th one carries the done pulse.
    assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/msb_gate_ctrl.sv
// MSB power-gating controller: registers operands for the adder, counts idle
// (non-wide) cycles and sequences the upper half through sleep/gate/wake.
//
// Handshake: a transfer happens on a rising edge where in_valid & in_ready.
// in_ready is combinational from state and the presented operands. The
// output side has no backpressure: out_valid is high for exactly the cycle
// after a transfer, and out_a/out_b/out_cin hold their value otherwise.
module msb_gate_ctrl
    import msb_gate_pkg::*;
#(
    parameter int IDLE_THRESH = DEF_IDLE_THRESH,
    parameter int SLEEP_LAT   = DEF_SLEEP_LAT,
    parameter int WAKE_LAT    = DEF_WAKE_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_cin,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        out_cin,
    output logic        out_valid,
    output logic        flag,
    output logic        msb_on,
    output state_e      o_dbg_state
);

    localparam int IW      = $clog2(IDLE_THRESH + 1);
    localparam int LAT_MAX = (SLEEP_LAT > WAKE_LAT) ? SLEEP_LAT : WAKE_LAT;
    localparam int TW      = $clog2(LAT_MAX + 1);

    state_e          r_state;
    logic [IW-1:0]   r_idle_cnt;
    logic            r_flag;
    logic            r_msb_on;
    logic            r_out_valid;
    logic [31:0]     r_out_a;
    logic [31:0]     r_out_b;
    logic            r_out_cin;

    logic            w_wide;
    logic            w_ready;
    logic            w_xfer;
    logic            w_tmr_done;
    logic            w_tmr_load;
    logic [TW-1:0]   w_tmr_val;
    logic            w_go_sleep;
    logic            w_go_gated;
    logic            w_go_wake;
    logic            w_go_active;

    assign w_wide = in_valid & is_wide(in_a[31:16], in_b[31:16]);

    // Acceptance depends on how much of the adder is powered right now.
    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            ACTIVE:          w_ready = 1'b1;
            SLEEPING, GATED: w_ready = ~w_wide;
            WAKING:          w_ready = 1'b0;
            default:         w_ready = 1'b0;
        endcase
    end

    assign w_xfer = in_valid & w_ready;

    // The >= also covers a counter that saturated while not ACTIVE (e.g.
    // upstream withdrew a wide operand during WAKING); otherwise it would
    // never pass through IDLE_THRESH-1 again and the block could not sleep.
    assign w_go_sleep  = (r_state == ACTIVE) & ~w_wide &
                         (r_idle_cnt >= IW'(IDLE_THRESH - 1));
    assign w_go_gated  = (r_state == SLEEPING) & w_tmr_done & ~w_wide;
    assign w_go_wake   = ((r_state == SLEEPING) & w_tmr_done & w_wide) |
                         ((r_state == GATED) & w_wide);
    assign w_go_active = (r_state == WAKING) & w_tmr_done;

    assign w_tmr_load = w_go_sleep | w_go_wake;
    assign w_tmr_val  = w_go_sleep ? TW'(SLEEP_LAT) : TW'(WAKE_LAT);

    lat_timer #(
        .W (TW)
    ) u_lat_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_done (w_tmr_done)
    );

    // Count consecutive non-wide cycles, saturating at the threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_wide) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IW'(IDLE_THRESH)) begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
        end
    end

    // Power-state sequencer with flag and msb_on registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ACTIVE;
            r_flag   <= 1'b0;
            r_msb_on <= 1'b1;
        end else if (w_go_sleep) begin
            r_state  <= SLEEPING;
            r_flag   <= 1'b1;
            r_msb_on <= 1'b0;
        end else if (w_go_gated) begin
            r_state  <= GATED;
            r_flag   <= 1'b1;
            r_msb_on <= 1'b0;
        end else if (w_go_wake) begin
            r_state  <= WAKING;
            r_flag   <= 1'b0;
            r_msb_on <= 1'b0;
        end else if (w_go_active) begin
            r_state  <= ACTIVE;
            r_flag   <= 1'b0;
            r_msb_on <= 1'b1;
        end
    end

    // Capture accepted operands; out_valid marks the cycle after a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_cin   <= 1'b0;
        end else begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_a   <= in_a;
                r_out_b   <= in_b;
                r_out_cin <= in_cin;
            end
        end
    end

    assign in_ready    = w_ready;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_cin     = r_out_cin;
    assign out_valid   = r_out_valid;
    assign flag        = r_flag;
    assign msb_on      = r_msb_on;
    assign o_dbg_state = r_state;

endmodule

// File: doc/msb_gate_ctrl.md
MSB_GATE_CTRL -- requirements
Module: msb_gate_ctrl

Interface
REQ-001 Parameter IDLE_THRESH, default 16: consecutive non-wide cycles required before requesting MSB power-down.
REQ-002 Parameter SLEEP_LAT, default 6: cycles held in SLEEPING, covering the power-down sequence (iso, ret, pse).
REQ-003 Parameter WAKE_LAT, default 6: cycles held in WAKING before wide operands are accepted again.
REQ-004 clk  input  1  single clock, rising edge; reset is asynchronous and active-low.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream operand pair valid.
REQ-007 in_ready  output  1  block accepts the operand pair this cycle.
REQ-008 in_a, in_b  input  32 each  operands.
REQ-009 in_cin  input  1  carry-in.
REQ-010 out_a, out_b  output  32 each  registered operands to the adder (A, B).
REQ-011 out_cin  output  1  registered carry-in to the adder (C_in).
REQ-012 out_valid  output  1  out_a/out_b/out_cin hold a new transfer this cycle.
REQ-013 flag  output  1  MSB power-down request to the adder; 1 = gate the MSB half.
REQ-014 msb_on  output  1  high only in ACTIVE.

Function
REQ-015 wide = in_valid & ((in_a[31:16] != 0) | (in_b[31:16] != 0)); narrow = in_valid & ~wide.
REQ-016 Transfer occurs on a cycle with in_valid & in_ready; out_* are registered on that edge and out_valid is high for exactly the following cycle (1-cycle latency, no downstream backpressure).
REQ-017 out_a/out_b/out_cin hold their last values when no transfer occurs.
REQ-018 idle_cnt increments on every cycle with no wide, saturates at IDLE_THRESH, and clears on any cycle with wide.
REQ-019 The FSM has four states: ACTIVE, SLEEPING, GATED, WAKING. flag is 1 in SLEEPING and GATED, and 0 in ACTIVE and WAKING.
REQ-020 ACTIVE: in_ready = 1. When idle_cnt == IDLE_THRESH-1 and the current cycle has no wide, the FSM moves to SLEEPING.
REQ-021 SLEEPING: runs for exactly SLEEP_LAT cycles and cannot be aborted. in_ready = ~wide. At expiry the FSM moves to GATED, or to WAKING if wide is present that cycle.
REQ-022 GATED: in_ready = ~wide; narrow transfers continue. A wide operand moves the FSM to WAKING on the next edge.
REQ-023 WAKING: in_ready = 0 for all operands; runs for exactly WAKE_LAT cycles, then moves to ACTIVE.
REQ-024 A wide operand held by upstream across the wake is accepted on the first ACTIVE cycle.
REQ-025 A narrow operand in the same cycle as the ACTIVE-to-SLEEPING transition is accepted.
REQ-026 in_ready is combinational from state and current operands; no transfer may occur without in_valid.
REQ-027 in_valid deassertion with in_ready low is permitted; the block holds no operand internally.

Reset
REQ-028 While rst_n is low: state = ACTIVE, idle_cnt = 0, latency timer = 0, flag = 0, out_valid = 0, out_a = out_b = 0, out_cin = 0, msb_on = 1.
REQ-029 Reset asserted mid-SLEEPING or mid-WAKING immediately forces the REQ-028 values; no partial sequence resumes after release.

Structure
REQ-030 Package msb_gate_pkg holds the state enum (ACTIVE, SLEEPING, GATED, WAKING) and the default IDLE_THRESH/SLEEP_LAT/WAKE_LAT constants.
REQ-031 A single sub-module lat_timer (loadable down-counter with a done pulse) serves both SLEEP_LAT and WAKE_LAT; idle_cnt stays in the top level.

Verification
REQ-032 Reset, then no valid for 16 cycles: flag rises on cycle 16 after reset release; msb_on falls; flag stays 1 through GATED.
REQ-033 GATED, present in_a=0x0000_1234, in_b=0x0000_0001: in_ready=1 and the next cycle shows out_valid=1, out_a=0x0000_1234; flag stays 1.
REQ-034 GATED, present in_a=0xFFFF_FFFF, in_b=0x8000_0000 held valid: flag drops next cycle, in_ready stays 0 for 6 cycles, transfer on cycle 7, and out_valid follows one cycle later.
REQ-035 Wide operand arrives on the 2nd SLEEPING cycle: flag stays 1 for the remaining SLEEP_LAT cycles, then WAKING (6 cycles), then acceptance; no transfer occurs before ACTIVE.
REQ-036 Wide operand on cycle 15 of the idle count: idle_cnt clears, flag never rises, and 16 further idle cycles are needed before sleeping.
REQ-037 rst_n pulsed low for 3 cycles mid-WAKING: flag=0, msb_on=1, out_valid=0 immediately; after release a wide operand is accepted in the first cycle.
